image_row_sequencer: RTL and testbench
======================================

# image_row_sequencer

Sequences full-frame reads of the binary image memory, one 1920-pixel row per access, and hands each row to the downstream text-extraction stages over a valid/ready handshake. It owns the memory's address and enable, compensates for the memory's fixed read latency, holds each captured row stable until the consumer accepts it, and marks the first and last row of the frame. It sits between the image memory (`readMemory`) and the row-scanning/segmentation logic.

## Interface
- `ROW_WIDTH`, 1920: pixels per row; this is the memory data width.
- `NUM_ROWS`, 1080: rows per frame; must be ≥ 1.
- `ADDR_W`, 11: memory address width; must satisfy 2^ADDR_W ≥ NUM_ROWS.
- `RD_LAT`, 1: memory read latency in cycles, from address/enable sampled to `douta` valid; must be ≥ 1.

Ports (clock and reset first):
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  begin a frame; honoured only in IDLE.
- `abort`  in  1  cancel the frame; honoured in every state except IDLE.
- `ena`  out  1  memory read enable.
- `addra`  out  ADDR_W  memory row address.
- `douta`  in  ROW_WIDTH  memory read data.
- `row_data`  out  ROW_WIDTH  captured row.
- `row_valid`  out  1  `row_data` and its sideband signals are valid.
- `row_ready`  in  1  consumer accepts the row.
- `row_idx`  out  ADDR_W  index of the row currently presented.
- `row_sof`  out  1  presented row is row 0.
- `row_eof`  out  1  presented row is row NUM_ROWS-1.
- `row_blank`  out  1  presented row is all zero; see Configuration.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse after the last row is accepted.

## Operation
- State machine: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE:
  - When `start`=1, clear the row counter to 0 and go to ISSUE.
- ISSUE:
  - Drive `ena`=1 and `addra`=counter for exactly 1 cycle.
  - Go to WAIT and load the wait counter with RD_LAT.
- WAIT:
  - Stays RD_LAT cycles. `ena`=0; `addra` holds its value.
  - In the last WAIT cycle, register `douta` into `row_data`, together with `row_idx`, `row_sof`, `row_eof` and `row_blank`.
  - Then go to PRESENT.
- PRESENT:
  - `row_valid`=1. All row outputs stay stable until a cycle in which `row_ready`=1.
  - On that transfer, if the counter = NUM_ROWS-1, go to DONE. Otherwise increment the counter and go to ISSUE.
- DONE:
  - `frame_done`=1 for 1 cycle, then go to IDLE.
- `start` is ignored outside IDLE, and there is no queuing of a second frame.
- `abort`=1 in ISSUE, WAIT or PRESENT moves the block to IDLE on the next edge:
  - `row_valid` and `ena` drop.
  - `frame_done` does not pulse.
  - Any pending memory data is discarded.
- `abort` in DONE also goes to IDLE, and the `frame_done` pulse already in flight completes.
- `abort` wins over `row_ready` in the same cycle: the row is not counted as transferred.
- Counter arithmetic is unsigned ADDR_W and never exceeds NUM_ROWS-1; there is no wrap-around.
- A frame with NUM_ROWS=1 has `row_sof`=`row_eof`=1 on its single row.

## Timing
- Reset (`rst_n`=0 at an edge) forces IDLE and sets every output to 0:
  - `ena`, `addra`, `row_data`, `row_valid`, `row_idx`, `row_sof`, `row_eof`, `row_blank`, `busy`, `frame_done`.
- Reset in any state, including mid-row, is a full reset. It takes priority over `abort` and `start`.
- With `start` sampled at edge E0:
  - `ena` is high in the cycle after E0.
  - `row_valid` first rises RD_LAT+2 cycles after E0.
- With `row_ready` held at 1, rows are delivered one every RD_LAT+2 cycles.
- Full-frame minimum length is NUM_ROWS×(RD_LAT+2)+1 cycles, including DONE.
- `row_valid` never depends combinationally on `row_ready`. All outputs are registered.
- `busy` rises the cycle after `start` is accepted and falls the cycle after DONE.

## Configuration
- `ROW_BLANK_FLAG_EN` defined:
  - `row_blank` = NOR-reduction of `douta`, registered at capture.
  - It lets downstream segmentation skip inter-line gaps cheaply.
- Not defined:
  - The reduction logic is omitted and `row_blank` is tied to 0.
  - The port list is unchanged.

## Test plan
Bench settings: NUM_ROWS=4, RD_LAT=1, memory model returns row r = {ROW_WIDTH{r[0]}}.
- Basic frame: pulse `start`, `row_ready`=1 → `ena`/`addra` sequence 0,1,2,3, each 3 cycles apart.
  - Four transfers with `row_idx` 0..3.
  - `row_sof` only on row 0 and `row_eof` only on row 3.
  - `frame_done` is a single pulse 13 cycles after `start`.
- Backpressure: `row_ready`=0 for 5 cycles on row 1 → `row_data`/`row_idx`=1 hold stable, there is no new `ena` pulse, and the row is accepted once.
- Abort: assert `abort` during WAIT of row 2 → IDLE next cycle, `row_valid`=0, `busy`=0, no `frame_done`.
  - A following `start` restarts at `addra`=0.
- Reset mid-PRESENT: `rst_n`=0 for 1 edge → all outputs 0 the next cycle.
  - `start` is ignored while `busy` was high before the reset.
- Blank flag: rows 0 and 2 are all zero.
  - With `ROW_BLANK_FLAG_EN` defined → `row_blank`=1,0,1,0.
  - Without it → always 0.
- Simultaneous `abort` and `row_ready` on row 3 → no `frame_done`, return to IDLE.

Source files
------------

// File: rtl/image_row_sequencer.sv
// Frame reader for the binary image memory: one row per access, latency-compensated capture, valid/ready hand-off.
// Optional macro ROW_BLANK_FLAG_EN adds a registered all-zero flag per captured row; otherwise row_blank is tied low.
module image_row_sequencer #(
    parameter int ROW_WIDTH = 1920,
    parameter int NUM_ROWS  = 1080,
    parameter int ADDR_W    = 11,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 ena,
    output logic [ADDR_W-1:0]    addra,
    input  logic [ROW_WIDTH-1:0] douta,
    output logic [ROW_WIDTH-1:0] row_data,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [ADDR_W-1:0]    row_idx,
    output logic                 row_sof,
    output logic                 row_eof,
    output logic                 row_blank,
    output logic                 busy,
    output logic                 frame_done
);
    // state     | meaning
    // S_IDLE    | waiting for start
    // S_ISSUE   | ena/addra driven for one cycle
    // S_WAIT    | covering memory read latency, capture on last cycle
    // S_PRESENT | row_valid high until row_ready
    // S_DONE    | frame_done pulse, then idle
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_PRESENT, S_DONE} state_t;

    localparam int WAIT_W = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(NUM_ROWS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LAT);

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   ena_q, ena_d;
    logic [ADDR_W-1:0]      addra_q, addra_d;
    logic [ROW_WIDTH-1:0]   row_data_q, row_data_d;
    logic                   row_valid_q, row_valid_d;
    logic [ADDR_W-1:0]      row_idx_q, row_idx_d;
    logic                   row_sof_q, row_sof_d;
    logic                   row_eof_q, row_eof_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   capture;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        addra_d     = addra_q;
        row_data_d  = row_data_q;
        row_idx_d   = row_idx_q;
        row_sof_d   = row_sof_q;
        row_eof_d   = row_eof_q;
        capture     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_d  = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_W'(1)) begin
                    capture = 1'b1;
                    state_d = S_PRESENT;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_PRESENT: begin
                if (row_ready) begin
                    if (cnt_q == LAST_ROW) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides any transfer or capture decided above.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            capture = 1'b0;
        end

        ena_d = (state_d == S_ISSUE);
        if (ena_d) begin
            addra_d = cnt_d;
        end
        if (capture) begin
            row_data_d = douta;
            row_idx_d  = cnt_q;
            row_sof_d  = (cnt_q == '0);
            row_eof_d  = (cnt_q == LAST_ROW);
        end
        row_valid_d  = (state_d == S_PRESENT);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wait_q       <= '0;
            ena_q        <= 1'b0;
            addra_q      <= '0;
            row_data_q   <= '0;
            row_valid_q  <= 1'b0;
            row_idx_q    <= '0;
            row_sof_q    <= 1'b0;
            row_eof_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            ena_q        <= ena_d;
            addra_q      <= addra_d;
            row_data_q   <= row_data_d;
            row_valid_q  <= row_valid_d;
            row_idx_q    <= row_idx_d;
            row_sof_q    <= row_sof_d;
            row_eof_q    <= row_eof_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef ROW_BLANK_FLAG_EN
    logic row_blank_q, row_blank_d;

    always_comb begin
        row_blank_d = row_blank_q;
        if (capture) begin
            row_blank_d = ~|douta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_blank_q <= 1'b0;
        end else begin
            row_blank_q <= row_blank_d;
        end
    end

    assign row_blank = row_blank_q;
`else
    assign row_blank = 1'b0;
`endif

    assign ena        = ena_q;
    assign addra      = addra_q;
    assign row_data   = row_data_q;
    assign row_valid  = row_valid_q;
    assign row_idx    = row_idx_q;
    assign row_sof    = row_sof_q;
    assign row_eof    = row_eof_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_image_row_sequencer.sv
// Scoreboard bench for image_row_sequencer: 4-row frames, 1-cycle memory model returning row r as all r[0].
module tb_image_row_sequencer;
    localparam int RW = 16;
    localparam int NR = 4;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, row_ready;
    logic          ena, row_valid, row_sof, row_eof, row_blank, busy, frame_done;
    logic [AW-1:0] addra, row_idx;
    logic [RW-1:0] douta = '0;
    logic [RW-1:0] row_data;

    image_row_sequencer #(.ROW_WIDTH(RW), .NUM_ROWS(NR), .ADDR_W(AW), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .ena(ena), .addra(addra), .douta(douta),
        .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
        .row_idx(row_idx), .row_sof(row_sof), .row_eof(row_eof), .row_blank(row_blank),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ena) douta <= {RW{addra[0]}};

    typedef struct {
        int idx;
        int data;
        int sof;
        int eof;
        int blank;
    } row_t;
    typedef struct {
        int addr;
        int cyc;
    } iss_t;

    row_t row_q[$];
    iss_t iss_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   fd_count = 0;
    int   fd_cycle = -1;
    int   s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic row_t exp_row(input int r);
        row_t e;
        e.idx  = r;
        e.data = (r % 2 == 1) ? 32'h0000_FFFF : 32'h0;
        e.sof  = (r == 0) ? 1 : 0;
        e.eof  = (r == NR - 1) ? 1 : 0;
`ifdef ROW_BLANK_FLAG_EN
        e.blank = (r % 2 == 0) ? 1 : 0;
`else
        e.blank = 0;
`endif
        return e;
    endfunction

    // Monitor: pops expected issues and transfers as the DUT presents them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ena) begin
                if (iss_q.size() == 0) begin
                    check("ena_unexpected_addr", int'(addra), -1);
                end else begin
                    iss_t ei;
                    ei = iss_q.pop_front();
                    check("ena_addr", int'(addra), ei.addr);
                    if (ei.cyc >= 0) check("ena_cycle", cyc, ei.cyc);
                end
            end
            if (row_valid && row_ready && !abort) begin
                if (row_q.size() == 0) begin
                    check("xfer_unexpected_idx", int'(row_idx), -1);
                end else begin
                    row_t er;
                    er = row_q.pop_front();
                    check("row_idx", int'(row_idx), er.idx);
                    check("row_data", int'(row_data), er.data);
                    check("row_sof", int'(row_sof), er.sof);
                    check("row_eof", int'(row_eof), er.eof);
                    check("row_blank", int'(row_blank), er.blank);
                end
            end
            if (frame_done) begin
                fd_count++;
                fd_cycle = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_frame(input int n_iss, input int n_rows, input bit timed, input int base);
        for (int r = 0; r < n_iss; r++) begin
            iss_t ei;
            ei.addr = r;
            ei.cyc  = timed ? base + 1 + 3 * r : -1;
            iss_q.push_back(ei);
        end
        for (int r = 0; r < n_rows; r++) row_q.push_back(exp_row(r));
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && busy; i++) tick();
        check("busy_timeout", int'(busy), 0);
    endtask

    task automatic wait_valid(input int bound);
        for (int i = 0; i < bound && !row_valid; i++) tick();
        check("valid_timeout", int'(row_valid), 1);
    endtask

    task automatic present_row(input int hold, input int r);
        row_t e;
        e = exp_row(r);
        wait_valid(20);
        for (int i = 0; i < hold; i++) begin
            check("bp_idx", int'(row_idx), r);
            check("bp_data", int'(row_data), e.data);
            check("bp_valid", int'(row_valid), 1);
            tick();
        end
        row_ready = 1'b1;
        tick();
        row_ready = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ena"}, int'(ena), 0);
        check({tag, "_addra"}, int'(addra), 0);
        check({tag, "_row_data"}, int'(row_data), 0);
        check({tag, "_row_valid"}, int'(row_valid), 0);
        check({tag, "_row_idx"}, int'(row_idx), 0);
        check({tag, "_row_sof"}, int'(row_sof), 0);
        check({tag, "_row_eof"}, int'(row_eof), 0);
        check({tag, "_row_blank"}, int'(row_blank), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; row_ready = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic frame with row_ready held high.
        row_ready = 1'b1;
        push_frame(NR, NR, 1'b1, cyc);
        pulse_start();
        wait_idle(40);
        check("basic_fd_count", fd_count, 1);
        check("basic_fd_latency", fd_cycle - s, 13);
        row_ready = 1'b0;
        tick();

        // Backpressure on row 1.
        push_frame(NR, NR, 1'b0, 0);
        pulse_start();
        for (int r = 0; r < NR; r++) present_row((r == 1) ? 5 : 0, r);
        wait_idle(10);
        check("bp_fd_count", fd_count, 2);

        // Abort during WAIT of row 2, then restart.
        row_ready = 1'b1;
        push_frame(3, 2, 1'b0, 0);
        pulse_start();
        for (int i = 0; i < 30 && !(ena && addra == AW'(2)); i++) tick();
        check("abort_reach_issue2", int'(ena && addra == AW'(2)), 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_row_valid", int'(row_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ena", int'(ena), 0);
        repeat (5) tick();
        check("abort_fd_count", fd_count, 2);
        push_frame(NR, NR, 1'b1, cyc);
        pulse_start();
        wait_idle(40);
        check("restart_fd_count", fd_count, 3);
        check("restart_fd_latency", fd_cycle - s, 13);
        row_ready = 1'b0;
        tick();

        // Reset mid-PRESENT; start while busy must be ignored.
        push_frame(1, 0, 1'b0, 0);
        pulse_start();
        wait_valid(20);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check("busy_start_valid", int'(row_valid), 1);
        check("busy_start_idx", int'(row_idx), 0);
        rst_n = 1'b0;
        tick();
        check_zero("midreset");
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_reset_busy", int'(busy), 0);

        // Abort together with row_ready on row 3.
        push_frame(NR, NR - 1, 1'b0, 0);
        pulse_start();
        for (int r = 0; r < NR - 1; r++) present_row(0, r);
        wait_valid(20);
        check("ar_row_idx", int'(row_idx), 3);
        abort = 1'b1;
        row_ready = 1'b1;
        tick();
        abort = 1'b0;
        row_ready = 1'b0;
        check("ar_row_valid", int'(row_valid), 0);
        check("ar_busy", int'(busy), 0);
        repeat (5) tick();
        check("ar_fd_count", fd_count, 3);

        check("row_q_left", row_q.size(), 0);
        check("iss_q_left", iss_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
